// File: rtl/add_order_dual_if.sv
// add_order_dual_if: order request, memory write handshake and book-state bundle for add_order_dual.
interface add_order_dual_if #(
  parameter int PRICE_W = 16,
  parameter int QTY_W   = 16,
  parameter int ID_W    = 8,
  parameter int CNT_W   = 9
);
  localparam int OW = 1 + QTY_W + ID_W + PRICE_W;
  logic [OW-1:0]      order_in;
  logic               start;
  logic               mem_valid;
  logic               dec_buy;
  logic               dec_sell;
  logic               mem_start;
  logic [ID_W:0]      mem_addr;
  logic [OW-1:0]      mem_data_w;
  logic               mem_is_write;
  logic               busy;
  logic               ready;
  logic               reject;
  logic               timeout_err;
  logic [CNT_W-1:0]   count_buy;
  logic [CNT_W-1:0]   count_sell;
  logic [PRICE_W-1:0] best_buy;
  logic [PRICE_W-1:0] best_sell;
  logic               best_buy_valid;
  logic               best_sell_valid;
  modport master (
    output order_in, start, mem_valid, dec_buy, dec_sell,
    input  mem_start, mem_addr, mem_data_w, mem_is_write, busy, ready, reject, timeout_err,
           count_buy, count_sell, best_buy, best_sell, best_buy_valid, best_sell_valid
  );
  modport slave (
    input  order_in, start, mem_valid, dec_buy, dec_sell,
    output mem_start, mem_addr, mem_data_w, mem_is_write, busy, ready, reject, timeout_err,
           count_buy, count_sell, best_buy, best_sell, best_buy_valid, best_sell_valid
  );
endinterface

// File: rtl/add_order_dual.sv
// add_order_dual: dual-side add-order engine writing to order memory at {side,id}.
// ADD_ORDER_DUAL_STATS_EN adds saturating accept/reject/timeout pulse counters.
module add_order_dual #(
  parameter int PRICE_W = 16,
  parameter int QTY_W   = 16,
  parameter int ID_W    = 8,
  parameter int DEPTH   = 255,
  parameter int CNT_W   = 9,
  parameter int TIMEOUT = 15
) (
  input logic clk_in,
  input logic rst_n,
  add_order_dual_if.slave io
`ifdef ADD_ORDER_DUAL_STATS_EN
  ,
  output logic [15:0] stat_accept,
  output logic [15:0] stat_reject,
  output logic [15:0] stat_timeout
`endif
);
  localparam int OW = 1 + QTY_W + ID_W + PRICE_W;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, nxt;
  logic [OW-1:0] ord;
  logic [TW-1:0] tcnt;
  logic mem_start, mem_is_write, reject, timeout_err;
  logic [CNT_W-1:0] cnt_b, cnt_s;
  logic [PRICE_W-1:0] best_b, best_s, price;
  logic bv_b, bv_s;
  logic rej, accept, commit, tmo, c_b, c_s, clr_b, clr_s;
  // rejection sees the count as it stands in the IDLE cycle, before any same-cycle dec
  assign rej = io.order_in[OW-2 -: QTY_W] == '0 ||
               (io.order_in[OW-1] ? cnt_b == CNT_W'(DEPTH) : cnt_s == CNT_W'(DEPTH));
  assign accept = state == IDLE && io.start && !rej;
  assign commit = state == WAIT && io.mem_valid;
  assign tmo    = state == WAIT && !io.mem_valid && tcnt == TW'(TIMEOUT - 1);
  assign price  = ord[PRICE_W-1:0];
  assign c_b    = commit && ord[OW-1];
  assign c_s    = commit && !ord[OW-1];
  assign clr_b  = !c_b && io.dec_buy && cnt_b == CNT_W'(1);
  assign clr_s  = !c_s && io.dec_sell && cnt_s == CNT_W'(1);
  always_comb begin
    nxt = state == IDLE ? (accept ? WAIT : IDLE) :
          state == WAIT ? (commit ? DONE : tmo ? IDLE : WAIT) : IDLE;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ord          <= '0;
      tcnt         <= '0;
      mem_start    <= 1'b0;
      mem_is_write <= 1'b0;
      reject       <= 1'b0;
      timeout_err  <= 1'b0;
      cnt_b        <= '0;
      cnt_s        <= '0;
      best_b       <= '0;
      best_s       <= '0;
      bv_b         <= 1'b0;
      bv_s         <= 1'b0;
    end else begin
      ord          <= (state == IDLE && io.start) ? io.order_in : ord;
      tcnt         <= state == WAIT ? tcnt + 1'b1 : '0;
      mem_start    <= accept;
      mem_is_write <= accept || (state == WAIT && !commit && !tmo);
      reject       <= state == IDLE && io.start && rej;
      timeout_err  <= tmo;
      // a commit and a removal on the same side cancel out in the count
      cnt_b  <= (c_b && io.dec_buy) ? cnt_b : c_b ? cnt_b + 1'b1 :
                (io.dec_buy && cnt_b != '0) ? cnt_b - 1'b1 : cnt_b;
      cnt_s  <= (c_s && io.dec_sell) ? cnt_s : c_s ? cnt_s + 1'b1 :
                (io.dec_sell && cnt_s != '0) ? cnt_s - 1'b1 : cnt_s;
      best_b <= clr_b ? '0 : (c_b && (!bv_b || price > best_b)) ? price : best_b;
      best_s <= clr_s ? '0 : (c_s && (!bv_s || price < best_s)) ? price : best_s;
      bv_b   <= clr_b ? 1'b0 : c_b ? 1'b1 : bv_b;
      bv_s   <= clr_s ? 1'b0 : c_s ? 1'b1 : bv_s;
    end
  end
`ifdef ADD_ORDER_DUAL_STATS_EN
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      stat_accept  <= '0;
      stat_reject  <= '0;
      stat_timeout <= '0;
    end else begin
      if (state == DONE && stat_accept != 16'hFFFF) stat_accept <= stat_accept + 16'd1;
      if (reject && stat_reject != 16'hFFFF) stat_reject <= stat_reject + 16'd1;
      if (timeout_err && stat_timeout != 16'hFFFF) stat_timeout <= stat_timeout + 16'd1;
    end
  end
`endif
  assign io.mem_start       = mem_start;
  assign io.mem_addr        = {ord[OW-1], ord[PRICE_W+ID_W-1 -: ID_W]};
  assign io.mem_data_w      = ord;
  assign io.mem_is_write    = mem_is_write;
  assign io.busy            = state != IDLE;
  assign io.ready           = state == DONE;
  assign io.reject          = reject;
  assign io.timeout_err     = timeout_err;
  assign io.count_buy       = cnt_b;
  assign io.count_sell      = cnt_s;
  assign io.best_buy        = best_b;
  assign io.best_sell       = best_s;
  assign io.best_buy_valid  = bv_b;
  assign io.best_sell_valid = bv_s;
endmodule

// File: doc/add_order_dual.md
Name: add_order_dual

Overview:
- Parametrised successor to the single-side add-order engine.
- Accepts one new order at a time for either book side (buy/sell, selected by a side bit in the order word) and writes it to order memory at address {side, order_id} over a start/valid handshake.
- Owns the per-side occupancy counts and best prices, committing them only after memory acknowledges. Adds capacity and zero-quantity rejection, a write-timeout abort, and external decrement inputs.

Parameters:
- PRICE_W, 16, price field width.
- QTY_W, 16, quantity field width.
- ID_W, 8, order-id width; memory address width is ID_W+1.
- DEPTH, 255, max live orders per side; must be ≤ 2**ID_W.
- CNT_W, 9, occupancy counter width; must satisfy 2**CNT_W > DEPTH.
- TIMEOUT, 15, max cycles spent in WAIT before abort.

Ports:
- clk_in, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- order_in, input, 1+QTY_W+ID_W+PRICE_W, {side(1=buy), qty, id, price}, MSB to LSB.
- start, input, 1, request; sampled only in IDLE.
- mem_valid, input, 1, memory write acknowledge.
- dec_buy, input, 1, one buy order removed elsewhere.
- dec_sell, input, 1, one sell order removed elsewhere.
- mem_start, output, 1, one-cycle write strobe.
- mem_addr, output, ID_W+1, {side, id}.
- mem_data_w, output, order width, order word.
- mem_is_write, output, 1, high from issue until leaving WAIT.
- busy, output, 1, high in any state other than IDLE.
- ready, output, 1, one-cycle pulse on successful commit.
- reject, output, 1, one-cycle pulse on rejection.
- timeout_err, output, 1, one-cycle pulse on write abort.
- count_buy, output, CNT_W, buy-side occupancy.
- count_sell, output, CNT_W, sell-side occupancy.
- best_buy, output, PRICE_W, best buy price.
- best_sell, output, PRICE_W, best sell price.
- best_buy_valid, output, 1, best_buy meaningful.
- best_sell_valid, output, 1, best_sell meaningful.

Behaviour:
- Reset (rst_n low at a clock edge): all outputs and internal registers go to 0; FSM goes to IDLE.
  - Reset mid-WAIT abandons the write without commit; any later mem_valid is ignored.
- FSM has three states: IDLE, WAIT, DONE.
- IDLE, start=1:
  - Latch order_in.
  - If qty==0 or the selected side's count==DEPTH: pulse reject next cycle and stay in IDLE.
  - Otherwise, next cycle: mem_start=1 (one cycle), mem_is_write=1, mem_addr/mem_data_w driven from the latched order; go to WAIT with the timeout counter cleared.
  - Latency: start at cycle N gives mem_start (or reject) at N+1.
- WAIT:
  - mem_valid=1: commit and go to DONE.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT without mem_valid: pulse timeout_err, clear mem_is_write, return to IDLE with no commit.
  - mem_valid arriving on the same cycle as the TIMEOUT boundary counts as success.
- Commit, registered on the WAIT-to-DONE edge:
  - Selected side count +1.
  - Buy side: best_buy = price if !best_buy_valid or price > best_buy; otherwise unchanged. Set best_buy_valid.
  - Sell side: same rule with price < best_sell, then set best_sell_valid.
  - Equal price leaves best unchanged.
- DONE: pulse ready for one cycle, clear mem_is_write, go to IDLE. Earliest next start is accepted in the cycle after ready.
- start while busy: ignored, not queued.
- dec_buy / dec_sell, accepted in any state:
  - Decrement the side's count, saturating at 0.
  - Commit and decrement on the same side in the same cycle leave count unchanged, but best still updates.
  - When a count reaches 0 through a decrement, clear that side's best_*_valid and zero its best price.
  - The best price is otherwise not recomputed on removal; that is the cancel path's responsibility.
- Rejection check uses the count value as seen in the IDLE cycle. A dec in that same cycle does not un-reject.
- Counter width: count never exceeds DEPTH, so CNT_W bits suffice and no wrap can occur.

Optional Feature:
- Macro ADD_ORDER_DUAL_STATS_EN.
- Defined: adds outputs stat_accept, stat_reject, stat_timeout, each 16 bits, counting ready, reject and timeout_err pulses respectively.
  - Each saturates at 16'hFFFF.
  - Cleared by reset only.
- Undefined: these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- Reset, then start with buy order qty=5 id=3 price=100; mem_valid two cycles after mem_start -> mem_addr=9'h103, ready pulse, count_buy=1, best_buy=100, best_buy_valid=1.
- Sell orders at prices 50, 40, 45 in sequence -> best_sell=50, 40, 40; count_sell=3; equal-price order at 40 leaves best_sell=40.
- Fill the buy side to 255 (DEPTH=255), then start one more -> reject pulse at N+1, no mem_start, count_buy stays 255. An order with qty=0 on an empty side also rejects.
- Never assert mem_valid -> timeout_err exactly 15 cycles after entering WAIT, count unchanged, busy low the next cycle; a late mem_valid is ignored.
- count_buy=1, best_buy=100; dec_buy -> count_buy=0, best_buy_valid=0. Commit plus dec_sell on the same side in the same cycle -> count_sell unchanged, best_sell updated.
- Pull rst_n low while in WAIT -> all outputs 0 on the next edge; mem_valid afterwards produces no ready. With ADD_ORDER_DUAL_STATS_EN defined, stat_accept/stat_reject/stat_timeout match the pulse counts of the scenarios above.
